// File: rtl/npu_dot_engine.sv
// npu_dot_engine: streaming LANES-wide dot-product engine with cross-beat accumulation.
// Pipeline: input capture -> product stage P -> log2(LANES) adder-tree stages -> accumulate stage A.
// Optional macro NPU_DOT_SAT_EN: clamp the accumulator to the signed ACC_W range and report out_sat;
// when undefined the accumulator wraps and out_sat is tied low.
module npu_dot_engine #(
    parameter int LANES  = 16,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_weight,
    input  logic [LANES*DATA_W-1:0]   in_act,
    input  logic                      in_act_signed,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_sat
);

    localparam int N  = $clog2(LANES);
    localparam int PW = 2*DATA_W + 1;          // product width
    localparam int TW = PW + N;                // tree root width, cannot overflow
    localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;

    // Whole pipeline freezes while a finished result waits for the consumer.
    logic adv;
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Input capture registers
    logic [LANES*DATA_W-1:0] w_q, a_q;
    logic                    s_q;
    logic                    v_q, l_q;

    // Product and tree nodes in heap order: leaves at LANES..2*LANES-1, root at 1.
    logic signed [PW-1:0] prod [LANES];
    logic signed [TW-1:0] node [1:2*LANES-1];
    logic [N:0]           pv, pl;              // valid/last per stage: [0]=P, [j]=Tj

    // Accumulator stage
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt, cnt_inc;
    logic [ACC_W-1:0]        sum_c;
    logic                    clamp;

    // Capture sidebands of an accepted beat; a stalled cycle keeps everything in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            l_q <= 1'b0;
            pv  <= '0;
            pl  <= '0;
        end else if (adv) begin
            v_q <= in_valid;
            l_q <= in_last;
            pv  <= {pv[N-1:0], v_q};
            pl  <= {pl[N-1:0], l_q};
        end
    end

    // Operand capture and registered adder tree.
    // NOTE: datapath registers carry no reset; only the valid sidebands decide whether their contents matter.
    always_ff @(posedge clk) begin
        if (adv) begin
            w_q <= in_weight;
            a_q <= in_act;
            s_q <= in_act_signed;
            for (int i = 0; i < LANES; i++) begin
                node[LANES+i] <= TW'(prod[i]);
            end
            for (int k = 1; k < LANES; k++) begin
                node[k] <= node[2*k] + node[2*k+1];
            end
        end
    end

    // Per-lane products: weight always signed, activation sign- or zero-extended by mode.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = PW'($signed({w_q[i*DATA_W+DATA_W-1], w_q[i*DATA_W +: DATA_W]}))
                    * PW'($signed({s_q & a_q[i*DATA_W+DATA_W-1], a_q[i*DATA_W +: DATA_W]}));
        end
    end

`ifdef NPU_DOT_SAT_EN
    localparam logic signed [SW-1:0] MAXV = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    logic signed [SW-1:0] sum_w;
    logic                 sat_flag;

    // Wide sum followed by clamp to the signed accumulator range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sum_w = SW'(acc) + SW'(node[1]);
        sum_c = sum_w[ACC_W-1:0];
        clamp = 1'b0;
        if (sum_w > MAXV) begin
            sum_c = MAXV[ACC_W-1:0];
            clamp = 1'b1;
        end else if (sum_w < MINV) begin
            sum_c = MINV[ACC_W-1:0];
            clamp = 1'b1;
        end
    end

    // Sticky clamp flag for the vector in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            out_sat  <= 1'b0;
        end else if (adv && pv[N]) begin
            if (pl[N]) begin
                out_sat  <= sat_flag | clamp;
                sat_flag <= 1'b0;
            end else begin
                sat_flag <= sat_flag | clamp;
            end
        end
    end
`else
    // Modulo-2^ACC_W accumulation.
    always_comb begin
        sum_c = acc + ACC_W'(node[1]);
        clamp = 1'b0;
    end

    assign out_sat = 1'b0;
`endif

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // Accumulate across beats; on the last beat publish the result and restart from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (adv) begin
            out_valid <= 1'b0;
            if (pv[N]) begin
                if (pl[N]) begin
                    out_valid <= 1'b1;
                    out_data  <= sum_c;
                    out_count <= cnt_inc;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum_c;
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_npu_dot_engine.sv
// Self-checking bench for npu_dot_engine: directed scenarios plus randomized vectors,
// compared against an arithmetic dot-product model with an expected-result queue.
module tb_npu_dot_engine;

    localparam int LANES  = 16;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int ACC_W2 = 20;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    in_valid = 1'b0, in_act_signed = 1'b1, in_last = 1'b0;
    logic                    out_ready = 1'b1, sel20 = 1'b0;
    logic [LANES*DATA_W-1:0] in_weight = '0, in_act = '0;
    logic                    in_ready, out_valid, out_sat;
    logic [ACC_W-1:0]        out_data;
    logic [CNT_W-1:0]        out_count;
    logic                    in_ready2, out_valid2, out_sat2;
    logic [ACC_W2-1:0]       out_data2;
    logic [CNT_W-1:0]        out_count2;
    logic                    v1, v2;

    assign v1 = in_valid & ~sel20;
    assign v2 = in_valid & sel20;

    npu_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(in_ready),
        .in_weight(in_weight), .in_act(in_act), .in_act_signed(in_act_signed), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_sat(out_sat)
    );

    npu_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W2), .CNT_W(CNT_W)) dut20 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(in_ready2),
        .in_weight(in_weight), .in_act(in_act), .in_act_signed(in_act_signed), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .out_count(out_count2), .out_sat(out_sat2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    typedef struct {
        longint data;
        int     count;
        bit     sat;
    } res_t;

    res_t   exp_q[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_sat = 1'b0;
    int     wv[LANES];
    int     av[LANES];
    int     acc_cyc = 0;

    function automatic longint dot(input bit sgn);
        longint s = 0;
        for (int i = 0; i < LANES; i++) begin
            s += longint'(wv[i]) * longint'((sgn && av[i] >= 128) ? av[i] - 256 : av[i]);
        end
        return s;
    endfunction

    function automatic longint fit(input longint s, input int w, output bit c);
        longint hi = (longint'(1) <<< (w-1)) - 1;
        longint lo = -(longint'(1) <<< (w-1));
        longint m  = longint'(1) <<< w;
        longint r;
        c = 1'b0;
`ifdef NPU_DOT_SAT_EN
        if (s > hi) begin c = 1'b1; return hi; end
        if (s < lo) begin c = 1'b1; return lo; end
        r = s + (m - m);
`else
        r = s & (m - 1);
        if (r > hi) r -= m;
        if (lo > r) r = lo;
`endif
        return r;
    endfunction

    task automatic set_all(input int w, input int a);
        for (int i = 0; i < LANES; i++) begin
            wv[i] = w;
            av[i] = a;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < LANES; i++) begin
            wv[i] = int'($urandom_range(0, 255)) - 128;
            av[i] = int'($urandom_range(0, 255));
        end
    endtask

    // Present one beat, wait (bounded) until accepted, then update the model.
    task automatic send(input bit sgn, input bit last);
        bit     ok = 1'b0;
        int     guard = 0;
        bit     c;
        longint s;
        for (int i = 0; i < LANES; i++) begin
            in_weight[i*DATA_W +: DATA_W] = wv[i][DATA_W-1:0];
            in_act[i*DATA_W +: DATA_W]    = av[i][DATA_W-1:0];
        end
        in_act_signed = sgn;
        in_last       = last;
        in_valid      = 1'b1;
        while (!ok && guard < 500) begin
            @(negedge clk);
            ok = sel20 ? in_ready2 : in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed in_ready=0 for %0d cycles expected acceptance", guard);
        end else if (!sel20) begin
            acc_cyc = cyc;
            s = fit(m_acc + dot(sgn), ACC_W, c);
            m_sat |= c;
            if (last) begin
                exp_q.push_back('{data: s, count: (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1, sat: m_sat});
                m_acc = 0;
                m_cnt = 0;
                m_sat = 1'b0;
            end else begin
                m_acc = s;
                m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
            end
        end
    endtask

    // ---------------- output monitor ----------------
    int               n_results = 0, last_out_cyc = 0, prev_out_cyc = 0, stall_cycles = 0;
    bit               hold_pend = 1'b0;
    logic [ACC_W-1:0] hold_data;
    logic [CNT_W-1:0] hold_cnt;

    always @(negedge clk) begin
        res_t             e;
        logic [ACC_W-1:0] ed;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            checks++;
            assert (in_ready === !(out_valid && !out_ready)) else begin
                errors++;
                $error("FAIL in_ready_rule observed %b expected %b", in_ready, !(out_valid && !out_ready));
            end
            if (!in_ready) stall_cycles++;
            if (hold_pend) begin
                checks++;
                assert (out_valid === 1'b1 && out_data === hold_data && out_count === hold_cnt) else begin
                    errors++;
                    $error("FAIL hold observed v=%b d=%0h c=%0d expected v=1 d=%0h c=%0d",
                           out_valid, out_data, out_count, hold_data, hold_cnt);
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_cnt  = out_count;
            if (out_valid && out_ready) begin
                prev_out_cyc = last_out_cyc;
                last_out_cyc = cyc;
                n_results++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL unexpected_result observed d=%0h c=%0d expected none", out_data, out_count);
                end else begin
                    e  = exp_q.pop_front();
                    ed = e.data[ACC_W-1:0];
                    assert (out_data === ed) else begin
                        errors++;
                        $error("FAIL out_data observed %0d expected %0d", $signed(out_data), e.data);
                    end
                    checks++;
                    assert (out_count === CNT_W'(e.count)) else begin
                        errors++;
                        $error("FAIL out_count observed %0d expected %0d", out_count, e.count);
                    end
                    checks++;
                    assert (out_sat === e.sat) else begin
                        errors++;
                        $error("FAIL out_sat observed %b expected %b", out_sat, e.sat);
                    end
                end
            end
        end
    end

    task automatic wait_results(input int n);
        int g = 0;
        while (n_results < n && g < 200) begin
            @(posedge clk);
            #3;
            g++;
        end
        if (n_results < n) begin
            checks++;
            errors++;
            $error("FAIL result_timeout observed %0d results expected %0d", n_results, n);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int               k1, n0, st0, g;
        bit               drv_done;
        logic [ACC_W2-1:0] e2;
        bit               es2;

        // reset values
        #2;
        checks++;
        assert (out_valid === 1'b0 && out_data === '0 && out_count === '0 && out_sat === 1'b0 && in_ready === 1'b1)
        else begin
            errors++;
            $error("FAIL reset_values observed v=%b d=%0h c=%0d s=%b r=%b expected 0 0 0 0 1",
                   out_valid, out_data, out_count, out_sat, in_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single beat of ones, latency check
        set_all(1, 1);
        send(1'b1, 1'b1);
        k1 = acc_cyc;
        wait_results(1);
        checks++;
        assert (last_out_cyc - k1 === 6) else begin
            errors++;
            $error("FAIL latency observed %0d expected 6", last_out_cyc - k1);
        end

        // signed extremes and unsigned activations
        set_all(-128, 127);
        send(1'b1, 1'b1);
        set_all(-1, 255);
        send(1'b0, 1'b1);
        wait_results(3);

        // 3-beat vector followed immediately by a 1-beat vector
        set_all(2, 3);
        send(1'b1, 1'b0);
        k1 = acc_cyc;
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        set_all(1, 1);
        send(1'b1, 1'b1);
        checks++;
        assert (acc_cyc - k1 === 3) else begin
            errors++;
            $error("FAIL back_to_back_accept observed %0d cycles expected 3", acc_cyc - k1);
        end
        wait_results(5);
        checks++;
        assert (last_out_cyc - prev_out_cyc === 1) else begin
            errors++;
            $error("FAIL consecutive_results observed gap %0d expected 1", last_out_cyc - prev_out_cyc);
        end

        // 8 vectors with a 10-cycle consumer stall in the middle
        n0  = n_results;
        st0 = stall_cycles;
        fork
            begin
                for (int v = 0; v < 8; v++) begin
                    int len = int'($urandom_range(1, 3));
                    for (int b = 0; b < len; b++) begin
                        set_rand();
                        send(1'($urandom_range(0, 1)), b == len - 1);
                    end
                end
            end
            begin
                repeat (10) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (10) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        wait_results(n0 + 8);
        checks++;
        assert (stall_cycles > st0) else begin
            errors++;
            $error("FAIL stall_seen observed %0d stall cycles expected >0", stall_cycles - st0);
        end

        // randomized vectors with random consumer backpressure
        n0       = n_results;
        drv_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 24; v++) begin
                    int len = int'($urandom_range(1, 5));
                    for (int b = 0; b < len; b++) begin
                        if ($urandom_range(0, 5) == 0) set_all(-128, int'($urandom_range(0, 1)) * 255);
                        else set_rand();
                        send(1'($urandom_range(0, 1)), b == len - 1);
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_results(n0 + 24);

        // narrow accumulator: three beats of 127*127 overflow a 20-bit range
        sel20 = 1'b1;
        set_all(127, 127);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        sel20 = 1'b0;
        g = 0;
        while (!out_valid2 && g < 50) begin
            @(posedge clk);
            #3;
            g++;
        end
`ifdef NPU_DOT_SAT_EN
        e2  = ACC_W2'(524287);
        es2 = 1'b1;
`else
        e2  = ACC_W2'(-274384);
        es2 = 1'b0;
`endif
        checks++;
        assert (out_valid2 === 1'b1 && out_data2 === e2 && out_sat2 === es2 && out_count2 === CNT_W'(3)) else begin
            errors++;
            $error("FAIL acc20 observed v=%b d=%0d s=%b c=%0d expected v=1 d=%0d s=%b c=3",
                   out_valid2, $signed(out_data2), out_sat2, out_count2, $signed(e2), es2);
        end

        // reset in the middle of a 4-beat vector
        @(posedge clk);
        #1;
        set_rand();
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        rst_n = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        m_sat = 1'b0;
        n0 = n_results;
        repeat (2) @(negedge clk);
        checks++;
        assert (out_valid === 1'b0 && out_count === '0 && in_ready === 1'b1) else begin
            errors++;
            $error("FAIL reset_midvector observed v=%b c=%0d r=%b expected 0 0 1", out_valid, out_count, in_ready);
        end
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        assert (n_results === n0) else begin
            errors++;
            $error("FAIL stale_result observed %0d results expected %0d", n_results, n0);
        end
        set_all(1, 1);
        send(1'b1, 1'b1);
        wait_results(n0 + 1);

        repeat (10) @(posedge clk);
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL drain observed %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case something stalls indefinitely.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
